// File: rtl/clock_divider_pkg.sv
// Shared constants for the clock divider bank: mode encoding, default
// parameter values and the config channel-index width helper.
package clock_divider_pkg;

  localparam bit MODE_TOGGLE = 1'b0;
  localparam bit MODE_PULSE  = 1'b1;

  localparam int          DEF_NCH   = 4;
  localparam int          DEF_WIDTH = 32;
  localparam int unsigned DEF_DIV   = 50000;
  localparam bit          DEF_MODE  = MODE_TOGGLE;

  // Width of a channel index; never zero, even for a single channel.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: active and shadow {div, mode}, pending flag, counter.
// Ports:
//   in_clk, rst_n      clock, async active-low reset
//   en                 run enable; low clears counter and output
//   sync_clr           restart counter/output and apply a waiting shadow
//   wr, wr_div/mode    accepted config write into the shadow
//   out_clk            divided clock (toggle) or one-cycle tick (pulse), a flop
//   pending            shadow waiting to be applied
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int          WIDTH        = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV  = DEF_DIV,
  parameter bit          DEFAULT_MODE = DEF_MODE
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  input  logic             wr_mode,
  output logic             out_clk,
  output logic             pending
);

  typedef struct packed {
    logic [WIDTH-1:0] div;
    logic             mode;
  } cfg_t;

  localparam cfg_t CFG_RST = '{div: WIDTH'(DEFAULT_DIV), mode: DEFAULT_MODE};

  cfg_t             act, shd;
  logic [WIDTH-1:0] cnt;
  logic             div_zero, wrap, apply;

  assign div_zero = (act.div == '0);
  // Compare against D-1 rather than incrementing past D, so D = 2^WIDTH-1
  // never needs a wider counter.
  assign wrap     = en & ~div_zero & (cnt == act.div - WIDTH'(1));
  // pending is only ever set on the acceptance edge, so a wrap on that same
  // edge cannot apply the new shadow; it waits for the next wrap.
  assign apply    = pending & (sync_clr | wrap | ~en | div_zero);

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      act     <= CFG_RST;
      shd     <= CFG_RST;
      cnt     <= '0;
      out_clk <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (apply) act <= shd;
      if (wr)    shd <= '{div: wr_div, mode: wr_mode};
      // wr only arrives when pending is clear, so it never races apply.
      pending <= wr | (pending & ~apply);

      if (sync_clr || apply || !en || div_zero) begin
        cnt     <= '0;
        out_clk <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        out_clk <= (act.mode == MODE_PULSE) ? 1'b1 : ~out_clk;
      end else begin
        cnt <= cnt + WIDTH'(1);
        if (act.mode == MODE_PULSE) out_clk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NCH independent clock dividers sharing one config port.
// Ports:
//   in_clk, rst_n          clock, async active-low reset
//   en[NCH]                per-channel run enable
//   sync_clr               restart all channels together and apply shadows
//   cfg_valid/cfg_ready    config handshake; ready = ~pending[cfg_ch]
//   cfg_ch/div/mode        target channel, new divisor, new mode
//   out_clk[NCH]           per-channel output, driven from flops
//   pending[NCH]           per-channel shadow waiting
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int          NCH          = DEF_NCH,
  parameter int          WIDTH        = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV  = DEF_DIV,
  parameter bit          DEFAULT_MODE = DEF_MODE
) (
  input  logic                       in_clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             en,
  input  logic                       sync_clr,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [ch_idx_w(NCH)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]           cfg_div,
  input  logic                       cfg_mode,
  output logic [NCH-1:0]             out_clk,
  output logic [NCH-1:0]             pending
);

  localparam int CHW = ch_idx_w(NCH);

  // Pending flags padded out to every index cfg_ch can encode; the padding is
  // zero, so a nonexistent channel reads ready and its write matches no one.
  logic [2**CHW-1:0] pend_pad;
  logic [NCH-1:0]    wr;

  assign pend_pad  = (2**CHW)'(pending);
  assign cfg_ready = ~pend_pad[cfg_ch];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = cfg_valid & cfg_ready & (cfg_ch == CHW'(i));

    clock_divider_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_MODE (DEFAULT_MODE)
    ) u_ch (
      .in_clk   (in_clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .sync_clr (sync_clr),
      .wr       (wr[i]),
      .wr_div   (cfg_div),
      .wr_mode  (cfg_mode),
      .out_clk  (out_clk[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic           in_clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           sync_clr, cfg_valid, cfg_mode;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_div;
  logic [NCH-1:0] out_clk, pending;

  int n_chk  = 0;
  int n_pass = 0;

  clock_divider_bank #(
    .NCH(NCH), .WIDTH(W), .DEFAULT_DIV(3), .DEFAULT_MODE(1'b0)
  ) dut (
    .in_clk(in_clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .out_clk(out_clk), .pending(pending)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is described by its active divisor/mode and the number of
  // counting cycles since it last restarted. Wraps happen whenever that count
  // reaches a multiple of D; the output follows arithmetically from it.
  int m_div[NCH], m_sdiv[NCH], m_age[NCH];
  bit m_mode[NCH], m_smode[NCH], m_pend[NCH];

  function automatic bit model_out(input int d, input bit mode, input int age);
    if (d == 0) return 1'b0;
    if (mode == 1'b0) return ((age / d) % 2) == 1;
    return (age > 0) && (age % d == 0);
  endfunction

  always @(posedge in_clk or negedge rst_n) begin : model
    bit acc, wrap, ap;
    logic [NCH-1:0] e_out, e_pend;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = 3; m_mode[i] = 0; m_sdiv[i] = 3; m_smode[i] = 0;
        m_pend[i] = 0; m_age[i] = 0;
      end
    end else begin
      acc = cfg_valid && !m_pend[cfg_ch];
      for (int i = 0; i < NCH; i++) begin
        wrap = 0;
        if (en[i] && m_div[i] >= 1) wrap = ((m_age[i] + 1) % m_div[i]) == 0;
        ap = m_pend[i] && (sync_clr || wrap || !en[i] || m_div[i] == 0);
        if (ap) begin
          m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; m_pend[i] = 0; m_age[i] = 0;
        end else if (sync_clr || !en[i] || m_div[i] == 0) m_age[i] = 0;
        else m_age[i]++;
        if (acc && cfg_ch == 2'(i)) begin
          m_sdiv[i] = int'(cfg_div); m_smode[i] = cfg_mode; m_pend[i] = 1;
        end
      end
      #1;
      for (int i = 0; i < NCH; i++) begin
        e_out[i]  = model_out(m_div[i], m_mode[i], m_age[i]);
        e_pend[i] = m_pend[i];
      end
      chk("model_out_clk", 32'(out_clk), 32'(e_out));
      chk("model_pending", 32'(pending), 32'(e_pend));
      chk("model_cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic wr_cfg(input logic [1:0] ch, input logic [W-1:0] d, input logic m);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = d; cfg_mode = m;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [11:0] h0, h3;
    logic [9:0]  h1;
    logic [7:0]  h2;
    logic [3:0]  g0, g1, g2, g3;
    logic [5:0]  r0;
    int          pulses;

    rst_n = 1'b0; en = '0; sync_clr = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0; cfg_mode = 0;
    cyc(2);
    chk("rst_out_clk", 32'(out_clk), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);

    // Defaults: D=3 toggle, all channels in phase
    rst_n = 1'b1; en = 4'hF;
    for (int k = 0; k < 12; k++) begin
      cyc(1); h0[k] = out_clk[0]; h3[k] = out_clk[3];
    end
    chk("dflt_ch0_wave", 32'(h0), 32'(12'b011100011100));
    chk("dflt_ch3_wave", 32'(h3), 32'(12'b011100011100));

    // ch1 <- D=5 pulse mid-period; applied at the wrap at count 15
    wr_cfg(2'd1, 8'd5, 1'b1);
    chk("ch1_ready_before", 32'(cfg_ready), 1);
    cyc(1); cfg_valid = 0;
    chk("ch1_pending_set", 32'(pending), 32'(4'b0010));
    chk("ch1_ready_low", 32'(cfg_ready), 0);
    cyc(1);
    chk("ch1_still_pending", 32'(pending), 32'(4'b0010));
    cyc(1);
    chk("ch1_applied", 32'(pending), 0);
    chk("ch1_out_after_apply", 32'(out_clk[1]), 0);
    for (int k = 0; k < 10; k++) begin cyc(1); h1[k] = out_clk[1]; end
    chk("ch1_pulse_wave", 32'(h1), 32'(10'b1000010000));

    // ch2 <- D=0 (frozen), then D=2 toggle applied next cycle
    wr_cfg(2'd2, 8'd0, 1'b0);
    cyc(1); cfg_valid = 0;
    cyc(1);
    chk("ch2_d0_applied", 32'(pending[2]), 0);
    for (int k = 0; k < 5; k++) begin cyc(1); chk("ch2_d0_low", 32'(out_clk[2]), 0); end
    wr_cfg(2'd2, 8'd2, 1'b0);
    cyc(1); cfg_valid = 0;
    chk("ch2_d2_pending", 32'(pending[2]), 1);
    cyc(1);
    chk("ch2_d2_applied", 32'(pending[2]), 0);
    for (int k = 0; k < 8; k++) begin cyc(1); h2[k] = out_clk[2]; end
    chk("ch2_d2_wave", 32'(h2), 32'(8'b01100110));

    // ch0 <- D=4, forced in by sync_clr; then D=2 accepted on a wrap edge
    wr_cfg(2'd0, 8'd4, 1'b0);
    cyc(1); cfg_valid = 0; sync_clr = 1;
    cyc(1); sync_clr = 0;
    chk("sclr_pending", 32'(pending), 0);
    chk("sclr_out", 32'(out_clk), 0);
    cyc(3);
    wr_cfg(2'd0, 8'd2, 1'b0);
    cyc(1); cfg_valid = 0;
    chk("wrapacc_pending", 32'(pending[0]), 1);
    chk("wrapacc_out", 32'(out_clk[0]), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("oldper_out", 32'(out_clk[0]), 1);
      chk("oldper_pending", 32'(pending[0]), 1);
    end
    cyc(1);
    chk("newd_applied_out", 32'(out_clk[0]), 0);
    chk("newd_applied_pend", 32'(pending[0]), 0);
    for (int k = 0; k < 4; k++) begin cyc(1); g0[k] = out_clk[0]; end
    chk("ch0_d2_wave", 32'(g0), 32'(4'b0110));

    // en[3] dropped then raised: first toggle 3 cycles after re-enable
    en[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin cyc(1); chk("ch3_dis_low", 32'(out_clk[3]), 0); end
    en[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin cyc(1); g3[k] = out_clk[3]; end
    chk("ch3_reen_wave", 32'(g3), 32'(4'b1100));

    // Two channels pending, then sync_clr realigns and applies both
    sync_clr = 1; cyc(1); sync_clr = 0;
    wr_cfg(2'd1, 8'd4, 1'b0);
    cyc(1);
    wr_cfg(2'd3, 8'd2, 1'b1);
    cyc(1); cfg_valid = 0;
    chk("two_pending", 32'(pending), 32'(4'b1010));
    chk("two_pending_ready", 32'(cfg_ready), 0);
    sync_clr = 1; cyc(1); sync_clr = 0;
    chk("sclr2_pending", 32'(pending), 0);
    chk("sclr2_out", 32'(out_clk), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1); g0[k] = out_clk[0]; g1[k] = out_clk[1]; g2[k] = out_clk[2]; g3[k] = out_clk[3];
    end
    chk("align_ch0", 32'(g0), 32'(4'b0110));
    chk("align_ch1", 32'(g1), 32'(4'b1000));
    chk("align_ch2", 32'(g2), 32'(4'b0110));
    chk("align_ch3", 32'(g3), 32'(4'b1010));

    // Async reset mid-period with a pending write
    wr_cfg(2'd0, 8'd7, 1'b0);
    cyc(1); cfg_valid = 0;
    chk("pre_rst_pending", 32'(pending), 32'(4'b0001));
    chk("pre_rst_out", 32'(out_clk), 32'(4'b0010));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out_clk), 0);
    chk("async_rst_pending", 32'(pending), 0);
    chk("async_rst_ready", 32'(cfg_ready), 1);
    cyc(1); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin cyc(1); r0[k] = out_clk[0]; end
    chk("post_rst_wave", 32'(r0), 32'(6'b011100));

    // Maximum divisor 255 in pulse mode
    wr_cfg(2'd2, 8'd255, 1'b1);
    cyc(1); cfg_valid = 0;
    for (int k = 0; k < 10 && pending[2]; k++) cyc(1);
    chk("dmax_applied", 32'(pending[2]), 0);
    pulses = 0;
    for (int k = 0; k < 520; k++) begin cyc(1); pulses += int'(out_clk[2]); end
    chk("dmax_pulses", 32'(pulses), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
